branch_resolve_unit: RTL and testbench

//  Consumer end of the ID-stage equality comparator: takes its Zero flag (1 = operands differ) plus the decoded branch type.

---
 rtl/branch_pkg.sv | 31 +++
 rtl/branch_resolve_unit_if.sv | 44 ++++
 rtl/branch_flush_ctr.sv | 29 ++
 rtl/branch_resolve_unit.sv | 115 +++++++++++
 tb/tb_branch_resolve_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared branch-resolution types: FSM state encoding, branch-type codes and flush-length limits.
// Reused by the hazard unit and PC mux as well as branch_resolve_unit.
package branch_pkg;

  localparam int FLUSH_CYCLES_MAX = 7;
  localparam int FLUSH_CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } br_state_t;

  // Bit 0 = beq, bit 1 = bne; BR_BOTH is a malformed decode.
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_BOTH = 2'b11
  } br_type_t;

  function automatic br_type_t br_type(input logic is_beq, input logic is_bne);
    return br_type_t'({is_bne, is_beq});
  endfunction

  // zero = 1 means the compared registers differ.
  function automatic logic br_taken(input br_type_t t, input logic zero);
    return ((t == BR_BEQ) && !zero) || ((t == BR_BNE) && zero);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch bundle between the comparator/decoder (master) and branch_resolve_unit (slave).
// Optional statistics signals exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_unit_if #(
  parameter int ADDR_W = 32
);
  import branch_pkg::*;

  // Handshake: there is no ready; stall_i acts as inverse ready. A branch transfers on a rising
  // edge where br_valid_i=1, stall_i=0 and the unit is idle (busy_o=0); otherwise it is dropped.
  logic              br_valid_i;
  logic              is_beq_i;
  logic              is_bne_i;
  logic              zero_i;
  logic [ADDR_W-1:0] pc_plus4_i;
  logic [ADDR_W-1:0] imm_i;
  logic              stall_i;
  logic              redirect_o;
  logic [ADDR_W-1:0] target_o;
  logic              flush_o;
  logic              busy_o;
  logic              illegal_o;
  br_state_t         state_dbg;
`ifdef BRANCH_STATS_EN
  logic [31:0]       br_count_o;
  logic [31:0]       taken_count_o;
`endif

  modport master (
    output br_valid_i, is_beq_i, is_bne_i, zero_i, pc_plus4_i, imm_i, stall_i,
    input  redirect_o, target_o, flush_o, busy_o, illegal_o, state_dbg
`ifdef BRANCH_STATS_EN
    , input br_count_o, taken_count_o
`endif
  );

  modport slave (
    input  br_valid_i, is_beq_i, is_bne_i, zero_i, pc_plus4_i, imm_i, stall_i,
    output redirect_o, target_o, flush_o, busy_o, illegal_o, state_dbg
`ifdef BRANCH_STATS_EN
    , output br_count_o, taken_count_o
`endif
  );

endinterface

// File: rtl/branch_flush_ctr.sv
// Down-counter for the FLUSH phase: loads FLUSH_CYCLES, decrements each FLUSH cycle,
// o_done marks the final flush cycle.
module branch_flush_ctr
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  logic [FLUSH_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - FLUSH_CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == FLUSH_CNT_W'(1));

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves beq/bne from the ID comparator, registers the PC redirect and sequences the IF/ID flush.
// Define BRANCH_STATS_EN to add saturating accepted/taken branch counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);

  br_state_t         r_state;
  logic              r_redirect;
  logic              r_flush;
  logic              r_busy;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_target;

  br_type_t          w_type;
  logic              w_accept;
  logic              w_taken;
  logic              w_flush_done;
  logic [ADDR_W-1:0] w_target;

  assign w_type   = br_type(bus.is_beq_i, bus.is_bne_i);
  assign w_accept = bus.br_valid_i && !bus.stall_i && (r_state == ST_IDLE);
  assign w_taken  = br_taken(w_type, bus.zero_i);
  // Word offset; wraps modulo 2^ADDR_W by design.
  assign w_target = bus.pc_plus4_i + (bus.imm_i << 2);

  branch_flush_ctr #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_load(r_state == ST_REDIRECT),
    .i_dec (r_state == ST_FLUSH),
    .o_done(w_flush_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      r_busy     <= 1'b0;
      r_illegal  <= 1'b0;
      r_target   <= '0;
    end else begin
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_taken) begin
            r_state    <= ST_REDIRECT;
            r_target   <= w_target;
            r_redirect <= 1'b1;
            r_flush    <= 1'b1;
            r_busy     <= 1'b1;
          end
          if (w_accept && (w_type == BR_BOTH)) begin
            r_illegal <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (w_flush_done) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redirect_o = r_redirect;
  assign bus.target_o   = r_target;
  assign bus.flush_o    = r_flush;
  assign bus.busy_o     = r_busy;
  assign bus.illegal_o  = r_illegal;
  assign bus.state_dbg  = r_state;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_taken_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      if (w_accept && (w_type inside {BR_BEQ, BR_BNE}) && (r_br_count != '1)) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (w_accept && w_taken && (r_taken_count != '1)) begin
        r_taken_count <= r_taken_count + 32'd1;
      end
    end
  end

  assign bus.br_count_o    = r_br_count;
  assign bus.taken_count_o = r_taken_count;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit; per-cycle expected outputs queued in a scoreboard.
// Build with +define+BRANCH_STATS_EN to also check the statistics counters.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int FC = 3;
  localparam int W  = 38;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [W-1:0] exp_q[$];

  branch_resolve_unit_if #(.ADDR_W(32)) bus ();

  branch_resolve_unit #(
    .FLUSH_CYCLES(FC),
    .ADDR_W      (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {state[1:0], redirect, flush, busy, illegal, target[31:0]}
  function automatic logic [W-1:0] obs();
    return {2'(bus.state_dbg), bus.redirect_o, bus.flush_o, bus.busy_o, bus.illegal_o, bus.target_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic beq, input logic bne, input logic z,
                       input logic [31:0] pc, input logic [31:0] imm, input logic st);
    bus.br_valid_i = v;
    bus.is_beq_i   = beq;
    bus.is_bne_i   = bne;
    bus.zero_i     = z;
    bus.pc_plus4_i = pc;
    bus.imm_i      = imm;
    bus.stall_i    = st;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic push_idle(input int n, input logic [31:0] tgt);
    for (int i = 0; i < n; i++) exp_q.push_back({2'd0, 4'b0000, tgt});
  endtask

  task automatic push_taken(input logic [31:0] tgt);
    exp_q.push_back({2'd1, 4'b1110, tgt});
    for (int i = 0; i < FC; i++) exp_q.push_back({2'd2, 4'b0110, tgt});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++;
      if (obs() !== '0) $display("FAIL reset cyc%0d: got %h expected %h", k, obs(), {W{1'b0}});
      else n_pass++;
    end
`ifdef BRANCH_STATS_EN
    n_total++;
    if ({bus.br_count_o, bus.taken_count_o} !== 64'h0)
      $display("FAIL reset_stats: got %h expected 0", {bus.br_count_o, bus.taken_count_o});
    else n_pass++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_beq_taken();
    logic [W-1:0] e;
    int k;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0003, 1'b0);
    push_taken(32'h0000_0110);
    push_idle(2, 32'h0000_0110);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL beq_taken cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 0) drive_idle();
      k++;
    end
  endtask

  task automatic test_not_taken();
    logic [W-1:0] e;
    int k;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0800, 32'h0000_0040, 1'b0);
    push_idle(3, 32'h0000_0110);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL not_taken cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 0) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0900, 32'h0000_0040, 1'b0);
      if (k == 1) drive_idle();
      k++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0010, 1'b0);
    push_taken(32'h0000_0240);
    push_idle(2, 32'h0000_0240);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL bne_taken cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 0) drive_idle();
      k++;
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    int k;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0);
    push_taken(32'h0000_0000);
    push_idle(1, 32'h0000_0000);
    push_taken(32'h0000_0000);
    push_idle(1, 32'h0000_0000);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL wrap cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 0) drive_idle();
      if (k == FC) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0001, 1'b0);
      if (k == FC + 2) drive_idle();
      k++;
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    int k;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0008, 1'b1);
    push_idle(3, 32'h0000_0000);
    push_taken(32'h0000_0420);
    push_idle(2, 32'h0000_0420);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL stall cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 2) bus.stall_i = 1'b0;
      if (k == 3) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      if (k == 3 + FC) bus.stall_i = 1'b0;
      k++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    int k;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0004, 1'b0);
    push_taken(32'h0000_1010);
    push_idle(1, 32'h0000_1010);
    push_taken(32'h0000_1110);
    push_idle(2, 32'h0000_1110);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL back_to_back cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 1) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0020, 1'b0);
      if (k == FC) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1100, 32'h0000_0004, 1'b0);
      if (k == FC + 2) drive_idle();
      k++;
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] e;
    int k;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0001, 1'b0);
    exp_q.push_back({2'd0, 4'b0001, 32'h0000_1110});
    push_idle(2, 32'h0000_1110);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL illegal cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 0) drive_idle();
      k++;
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    int k;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0000, 1'b0);
    exp_q.push_back({2'd1, 4'b1110, 32'h0000_0300});
    exp_q.push_back({2'd2, 4'b0110, 32'h0000_0300});
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL async_pre cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      if (k == 0) drive_idle();
      k++;
    end
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (obs() !== '0) $display("FAIL async_reset: got %h expected %h", obs(), {W{1'b0}});
    else n_pass++;
`ifdef BRANCH_STATS_EN
    n_total++;
    if ({bus.br_count_o, bus.taken_count_o} !== 64'h0)
      $display("FAIL async_reset_stats: got %h expected 0", {bus.br_count_o, bus.taken_count_o});
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    push_idle(2, 32'h0000_0000);
    k = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (obs() !== e) $display("FAIL async_post cyc%0d: got %h expected %h", k, obs(), e);
      else n_pass++;
      k++;
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    logic [3:0] seq_beq  = 4'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1, 1'b0); @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1, 1'b0); @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 1'b0); @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h1, 1'b0); @(negedge clk);
    drive_idle();
    repeat (FC + 1) @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h1, 1'b0); @(negedge clk);
    drive_idle();
    repeat (FC + 1) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h1, 1'b0); @(negedge clk);
    drive_idle();
    @(negedge clk);
    seq_beq = 4'd5;
    n_total++;
    if (bus.br_count_o !== {28'h0, seq_beq})
      $display("FAIL br_count: got %0d expected 5", bus.br_count_o);
    else n_pass++;
    n_total++;
    if (bus.taken_count_o !== 32'd2)
      $display("FAIL taken_count: got %0d expected 2", bus.taken_count_o);
    else n_pass++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive_idle();
    test_reset();
    test_beq_taken();
    test_not_taken();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_async_reset();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
